// File: rtl/vga_pkg.sv
// Shared types and default timing for the VGA raster generator (640x480@60).
package vga_pkg;

    typedef logic [23:0] rgb24_t;

    // Default horizontal timing, in pixels
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;

    // Default vertical timing, in lines
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    // Test-pattern colour bars, left to right
    localparam int unsigned VGA_BAR_NUM = 8;
    localparam rgb24_t VGA_BAR_COLORS [VGA_BAR_NUM] = '{
        24'hFFFFFF,  // white
        24'hFFFF00,  // yellow
        24'h00FFFF,  // cyan
        24'h00FF00,  // green
        24'hFF00FF,  // magenta
        24'hFF0000,  // red
        24'h0000FF,  // blue
        24'h000000   // black
    };

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster-side bundle of the VGA timing generator: coordinates, strobes, colour and sync.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic [31:0] x_pos_o;
    logic [31:0] y_pos_o;
    logic        pix_tick_o;
    logic        frame_start_o;
    rgb24_t      rgb_i;
    rgb24_t      rgb_o;
    logic        hsync_o;
    logic        vsync_o;
    logic        de_o;

    // Timing generator side
    modport master (
        output x_pos_o, y_pos_o, pix_tick_o, frame_start_o,
        output rgb_o, hsync_o, vsync_o, de_o,
        input  rgb_i
    );

    // Renderer / DAC side
    modport slave (
        input  x_pos_o, y_pos_o, pix_tick_o, frame_start_o,
        input  rgb_o, hsync_o, vsync_o, de_o,
        output rgb_i
    );

endinterface

// File: rtl/sync_delay_line.sv
// Enabled shift register of Depth stages with a parameterised async reset value.
// Depth == 0 degenerates to a straight wire.
module sync_delay_line #(
    parameter int unsigned      Width  = 1,
    parameter int unsigned      Depth  = 1,
    parameter logic [Width-1:0] RstVal = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [Width-1:0] i_data,
    output logic [Width-1:0] o_data
);

    if (Depth == 0) begin : g_bypass
        assign o_data = i_data;
    end else begin : g_stages
        logic [Width-1:0] r_stage [Depth];

        // Advance every stage by one when enabled; stage 0 captures the input
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < int'(Depth); i++) begin
                    r_stage[i] <= RstVal;
                end
            end else if (i_en) begin
                r_stage[0] <= i_data;
                for (int i = 1; i < int'(Depth); i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_data = r_stage[Depth-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel divider, h/v counters, delayed sync/de and
// black-gated colour output. Optional macro VGA_TEST_PATTERN_EN replaces rgb_i
// with eight vertical colour bars.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned PIPE_DLY = 1
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] r_div_cnt;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    rgb24_t        r_rgb;

    logic   w_tick;
    logic   w_line_end;
    logic   w_frame_end;
    logic   w_hs_raw;
    logic   w_vs_raw;
    logic   w_de_raw;
    logic   w_hs_dly;
    logic   w_vs_dly;
    logic   w_de_dly;
    rgb24_t w_rgb_src;

    // Tick is masked during reset so a CLK_DIV of 1 still reads 0 while held
    assign w_tick      = (r_div_cnt == DIV_LAST) && !rst;
    assign w_line_end  = (r_h_cnt == H_LAST);
    assign w_frame_end = w_line_end && (r_v_cnt == V_LAST);

    // Pixel divider: counts 0..CLK_DIV-1, wrapping on the tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Raster position: column advances per tick, line advances on column wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_tick) begin
            if (w_line_end) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_frame_end ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    assign w_hs_raw = !((r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END));
    assign w_vs_raw = !((r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END));
    assign w_de_raw = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);

    // Sync/de aligned with the renderers' memory latency; idle value is syncs high, de low
    sync_delay_line #(
        .Width  (3),
        .Depth  (PIPE_DLY),
        .RstVal (3'b110)
    ) u_sync_dly (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_tick),
        .i_data ({w_hs_raw, w_vs_raw, w_de_raw}),
        .o_data ({w_hs_dly, w_vs_dly, w_de_dly})
    );

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / VGA_BAR_NUM;

    logic [2:0] w_bar_idx;
    rgb24_t     w_bar_rgb;

    // Outside the active columns the colour is gated off anyway; park on black
    assign w_bar_idx = (r_h_cnt < H_ACT_END) ? 3'(r_h_cnt / HW'(BAR_W)) : 3'd7;
    assign w_bar_rgb = VGA_BAR_COLORS[w_bar_idx];

    // Bars travel the same latency as real renderer output
    sync_delay_line #(
        .Width  (24),
        .Depth  (PIPE_DLY),
        .RstVal (24'h0)
    ) u_bar_dly (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_tick),
        .i_data (w_bar_rgb),
        .o_data (w_rgb_src)
    );
`else
    assign w_rgb_src = bus.rgb_i;
`endif

    // Colour register: pass the source only while the delayed data enable is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
        end else if (w_tick) begin
            r_rgb <= w_de_dly ? w_rgb_src : '0;
        end
    end

    assign bus.x_pos_o       = 32'(r_h_cnt);
    assign bus.y_pos_o       = 32'(r_v_cnt);
    assign bus.pix_tick_o    = w_tick;
    assign bus.frame_start_o = w_tick && w_frame_end;
    assign bus.rgb_o         = r_rgb;
    assign bus.hsync_o       = w_hs_dly;
    assign bus.vsync_o       = w_vs_dly;
    // Masked in reset so a zero-depth delay line still reads de low
    assign bus.de_o          = w_de_dly && !rst;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: two small-raster instances (CLK_DIV=2/PIPE_DLY=1 and
// CLK_DIV=1/PIPE_DLY=2) compared every clk against a tick-index raster model.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 8, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int DIV_A = 2, DLY_A = 1;
    localparam int DIV_B = 1, DLY_B = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] hist [2][4096];
    bit agg_on = 1'b0;
    int agg_hs [2];
    int agg_vs [2];
    int agg_de [2];
    int agg_fs [2];

    always #5 clk = ~clk;

    vga_timing_gen_if bus_a ();
    vga_timing_gen_if bus_b ();

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .CLK_DIV  (DIV_A), .PIPE_DLY (DLY_A)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .CLK_DIV  (DIV_B), .PIPE_DLY (DLY_B)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {hsync, vsync, de} for the raster position reached after q ticks
    function automatic logic [2:0] raw_of(input int q);
        int p, x, y;
        logic hs, vs, de;
        p  = q % FT;
        x  = p % HT;
        y  = p / HT;
        hs = !((x >= HA + HF) && (x < HA + HF + HS));
        vs = !((y >= VA + VF) && (y < VA + VF + VS));
        de = (x < HA) && (y < VA);
        return {hs, vs, de};
    endfunction

    function automatic logic [23:0] bar_of(input int x);
        case (x / (HA / 8))
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // e = clk edges since reset release; outputs reflect the state after edge e
    task automatic check_dut(input int id, input int div, input int dly, input int e,
                             input logic [31:0] x, input logic [31:0] y,
                             input logic tick, input logic fs, input logic hs,
                             input logic vs, input logic de, input logic [23:0] rgb);
        int k, p, q;
        logic t_exp, fs_exp;
        logic [2:0] sd, r;
        logic [23:0] c_exp;
        string nm;
        nm     = (id == 0) ? "a" : "b";
        k      = e / div;
        p      = k % FT;
        t_exp  = ((e + 1) % div) == 0;
        fs_exp = t_exp && (((k + 1) % FT) == 0);
        sd     = (k >= dly) ? raw_of(k - dly) : 3'b110;
        c_exp  = '0;
        if (k >= dly + 1) begin
            q = k - 1 - dly;
            r = raw_of(q);
            if (r[0]) begin
`ifdef VGA_TEST_PATTERN_EN
                c_exp = bar_of((q % FT) % HT);
`else
                c_exp = hist[id][k];
`endif
            end
        end
        check_val($sformatf("%s.x e=%0d", nm, e), x, 32'(p % HT));
        check_val($sformatf("%s.y e=%0d", nm, e), y, 32'(p / HT));
        check_val($sformatf("%s.tick e=%0d", nm, e), 32'(tick), 32'(t_exp));
        check_val($sformatf("%s.frame_start e=%0d", nm, e), 32'(fs), 32'(fs_exp));
        check_val($sformatf("%s.hsync e=%0d", nm, e), 32'(hs), 32'(sd[2]));
        check_val($sformatf("%s.vsync e=%0d", nm, e), 32'(vs), 32'(sd[1]));
        check_val($sformatf("%s.de e=%0d", nm, e), 32'(de), 32'(sd[0]));
        check_val($sformatf("%s.rgb e=%0d", nm, e), 32'(rgb), 32'(c_exp));
        // Whole-frame totals over the first two frames, one sample per tick position
        if (agg_on && t_exp && k < 2 * FT) begin
            agg_hs[id] += int'(!hs);
            agg_vs[id] += int'(!vs);
            agg_de[id] += int'(de);
            agg_fs[id] += int'(fs);
        end
    endtask

    task automatic check_both(input int e);
        check_dut(0, DIV_A, DLY_A, e, bus_a.x_pos_o, bus_a.y_pos_o, bus_a.pix_tick_o,
                  bus_a.frame_start_o, bus_a.hsync_o, bus_a.vsync_o, bus_a.de_o, bus_a.rgb_o);
        check_dut(1, DIV_B, DLY_B, e, bus_b.x_pos_o, bus_b.y_pos_o, bus_b.pix_tick_o,
                  bus_b.frame_start_o, bus_b.hsync_o, bus_b.vsync_o, bus_b.de_o, bus_b.rgb_o);
    endtask

    task automatic check_rst(input string nm, input logic [31:0] x, input logic [31:0] y,
                             input logic tick, input logic fs, input logic hs,
                             input logic vs, input logic de, input logic [23:0] rgb);
        check_val({nm, " rst x"}, x, 32'd0);
        check_val({nm, " rst y"}, y, 32'd0);
        check_val({nm, " rst tick"}, 32'(tick), 32'd0);
        check_val({nm, " rst frame_start"}, 32'(fs), 32'd0);
        check_val({nm, " rst hsync"}, 32'(hs), 32'd1);
        check_val({nm, " rst vsync"}, 32'(vs), 32'd1);
        check_val({nm, " rst de"}, 32'(de), 32'd0);
        check_val({nm, " rst rgb"}, 32'(rgb), 32'd0);
    endtask

    task automatic check_rst_both(input string when);
        check_rst({when, " a"}, bus_a.x_pos_o, bus_a.y_pos_o, bus_a.pix_tick_o,
                  bus_a.frame_start_o, bus_a.hsync_o, bus_a.vsync_o, bus_a.de_o, bus_a.rgb_o);
        check_rst({when, " b"}, bus_b.x_pos_o, bus_b.y_pos_o, bus_b.pix_tick_o,
                  bus_b.frame_start_o, bus_b.hsync_o, bus_b.vsync_o, bus_b.de_o, bus_b.rgb_o);
    endtask

    // Present colour for the coming edge; remember it if that edge is a tick
    task automatic drive_rgb(input int e, input bit rnd);
        logic [23:0] va, vb;
        va = rnd ? 24'($urandom) : 24'hFFFFFF;
        vb = rnd ? 24'($urandom) : 24'hFFFFFF;
        bus_a.rgb_i = va;
        bus_b.rgb_i = vb;
        if (((e + 1) % DIV_A) == 0) hist[0][e / DIV_A + 1] = va;
        if (((e + 1) % DIV_B) == 0) hist[1][e / DIV_B + 1] = vb;
    endtask

    task automatic run_seg(input int n, input bit rnd);
        for (int e = 0; e < n; e++) begin
            check_both(e);
            drive_rgb(e, rnd);
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.rgb_i = '0;
        bus_b.rgb_i = '0;
        for (int i = 0; i < 2; i++) begin
            agg_hs[i] = 0;
            agg_vs[i] = 0;
            agg_de[i] = 0;
            agg_fs[i] = 0;
        end

        repeat (3) @(negedge clk);
        check_rst_both("init");

        // Constant white input over two full frames plus margin
        rst = 1'b0;
        #1;
        agg_on = 1'b1;
        run_seg(2 * DIV_A * FT + 20, 1'b0);
        agg_on = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("agg%0d hsync low ticks", i), 32'(agg_hs[i]), 32'(2 * HS * VT));
            check_val($sformatf("agg%0d vsync low ticks", i), 32'(agg_vs[i]), 32'(2 * VS * HT));
            check_val($sformatf("agg%0d de ticks", i), 32'(agg_de[i]), 32'(2 * HA * VA));
            check_val($sformatf("agg%0d frame_start", i), 32'(agg_fs[i]), 32'd2);
        end

        // Random colours, then reset while instance a is inside both sync pulses
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        run_seg(2 * ((VA + VF) * HT + HA + HF + HS / 2), 1'b1);
        check_both(2 * ((VA + VF) * HT + HA + HF + HS / 2));
        check_val("a pre-rst hsync", 32'(bus_a.hsync_o), 32'd0);
        check_val("a pre-rst vsync", 32'(bus_a.vsync_o), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_rst_both("async");

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        run_seg(700, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
